// File: rtl/spi_cmd_arbiter.sv
// Arbitrates SPI write-FIFO access between software command frames and
// auto-readout filler bursts triggered by the chip's data-ready interrupt.
module spi_cmd_arbiter #(
    parameter logic [7:0] IDLE_BYTE     = 8'hBC,
    parameter int         MAX_SW_FRAMES = 4,
    parameter int         TIMEOUT       = 65535
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [7:0]  sw_data,
    input  logic        sw_valid,
    input  logic        sw_last,
    output logic        sw_ready,
    input  logic        auto_en,
    input  logic [7:0]  auto_len,
    input  logic        interruptB,
    input  logic        spi_csb,
    output logic [7:0]  fifo_data,
    output logic        fifo_wr_en,
    input  logic        fifo_full,
    output logic [1:0]  grant,
    output logic [15:0] burst_cnt,
    output logic        timeout_err,
    input  logic        err_clr
);

    localparam int FCW = $clog2(MAX_SW_FRAMES + 2);
    localparam int TW  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SW_XFER,
        S_AUTO_XFER,
        S_WAIT_DONE
    } state_t;

    state_t          state_q, state_d;
    logic            irq_s1_q, irq_s2_q;
    logic            csb_s1_q, csb_s2_q;
    logic [FCW-1:0]  frame_cnt_q, frame_cnt_d;
    logic [7:0]      byte_cnt_q, byte_cnt_d;
    logic [TW-1:0]   wait_cnt_q, wait_cnt_d;
    logic            seen_low_q, seen_low_d;
    logic            is_burst_q, is_burst_d;
    logic [15:0]     burst_cnt_q, burst_cnt_d;
    logic            timeout_err_q, timeout_err_d;

    logic            auto_req;
    logic            sw_accept;

    // Both asynchronous inputs pass through two flops; csb idles high.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            irq_s1_q <= 1'b0;
            irq_s2_q <= 1'b0;
            csb_s1_q <= 1'b1;
            csb_s2_q <= 1'b1;
        end else begin
            irq_s1_q <= interruptB;
            irq_s2_q <= irq_s1_q;
            csb_s1_q <= spi_csb;
            csb_s2_q <= csb_s1_q;
        end
    end

    assign auto_req  = auto_en & ~irq_s2_q;
    assign sw_accept = sw_valid & ~fifo_full;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            frame_cnt_q   <= '0;
            byte_cnt_q    <= '0;
            wait_cnt_q    <= '0;
            seen_low_q    <= 1'b0;
            is_burst_q    <= 1'b0;
            burst_cnt_q   <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            frame_cnt_q   <= frame_cnt_d;
            byte_cnt_q    <= byte_cnt_d;
            wait_cnt_q    <= wait_cnt_d;
            seen_low_q    <= seen_low_d;
            is_burst_q    <= is_burst_d;
            burst_cnt_q   <= burst_cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        frame_cnt_d   = frame_cnt_q;
        byte_cnt_d    = byte_cnt_q;
        wait_cnt_d    = '0;
        seen_low_d    = seen_low_q;
        is_burst_d    = is_burst_q;
        burst_cnt_d   = burst_cnt_q;
        timeout_err_d = timeout_err_q & ~err_clr;
        sw_ready      = 1'b0;
        fifo_wr_en    = 1'b0;
        fifo_data     = 8'h00;
        grant         = 2'b00;

        case (state_q)
            S_IDLE: begin
                seen_low_d = 1'b0;
                // Software keeps priority until it has used its quota of
                // back-to-back frames against a waiting auto request.
                if (auto_req && (!sw_valid || frame_cnt_q >= FCW'(MAX_SW_FRAMES))) begin
                    state_d    = S_AUTO_XFER;
                    is_burst_d = 1'b1;
                    byte_cnt_d = (auto_len == 8'd0) ? 8'd1 : auto_len;
                end else if (sw_valid) begin
                    state_d    = S_SW_XFER;
                    is_burst_d = 1'b0;
                end
            end

            S_SW_XFER: begin
                grant      = 2'b01;
                sw_ready   = ~fifo_full;
                fifo_wr_en = sw_accept;
                fifo_data  = sw_data;
                if (sw_accept && sw_last) begin
                    state_d = S_WAIT_DONE;
                    if (!auto_req)
                        frame_cnt_d = '0;
                    else if (frame_cnt_q < FCW'(MAX_SW_FRAMES))
                        frame_cnt_d = frame_cnt_q + FCW'(1);
                end
            end

            S_AUTO_XFER: begin
                grant      = 2'b10;
                fifo_wr_en = ~fifo_full;
                fifo_data  = IDLE_BYTE;
                if (!fifo_full) begin
                    byte_cnt_d = byte_cnt_q - 8'd1;
                    if (byte_cnt_q == 8'd1) begin
                        state_d     = S_WAIT_DONE;
                        frame_cnt_d = '0;
                    end
                end
            end

            S_WAIT_DONE: begin
                grant      = is_burst_q ? 2'b10 : 2'b01;
                wait_cnt_d = wait_cnt_q + TW'(1);
                if (!csb_s2_q)
                    seen_low_d = 1'b1;
                if (seen_low_q && csb_s2_q) begin
                    state_d = S_IDLE;
                    if (is_burst_q)
                        burst_cnt_d = burst_cnt_q + 16'd1;
                end else if (wait_cnt_q == TW'(TIMEOUT - 1)) begin
                    // Setting the flag overrides a coincident err_clr.
                    state_d       = S_IDLE;
                    timeout_err_d = 1'b1;
                    if (is_burst_q)
                        burst_cnt_d = burst_cnt_q + 16'd1;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    assign burst_cnt   = burst_cnt_q;
    assign timeout_err = timeout_err_q;

endmodule
